mips_cpu_harvard_fetch: RTL and testbench
=========================================

# mips_cpu_harvard_fetch

Instruction-fetch stage of the Harvard MIPS CPU. It owns the PC and drives the instruction-memory port. It registers each fetched word into a single decode register, and implements the MIPS branch delay slot. It also detects the halt condition (a jump to address 0) and drives the CPU's `active` output, which the top-level bench polls.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC00000: PC value loaded on reset.
- `HALT_ADDRESS`, 32'h00000000: a fetch from this address stops the CPU.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clk_enable` in 1: when 0, all state holds.
- `stall` in 1: hazard hold from decode/execute.
- `branch_valid` in 1: the instruction in decode is a taken branch or jump.
- `branch_target` in 32: byte address of that branch or jump.
- `instr_readdata` in 32: word at `instr_address`, combinational, same cycle.
- `instr_address` out 32: current PC.
- `instr_read` out 1: fetch request.
- `instr_out` out 32: decode register.
- `instr_pc` out 32: address of `instr_out`.
- `instr_valid` out 1: `instr_out` must be executed this cycle.
- `link_address` out 32: `instr_pc + 8`, used by JAL/JALR/BxxAL.
- `active` out 1: CPU running.
- `fetch_error` out 1: sticky flag, misaligned branch target.

## Operation
- State register `fetch_state_t`: FIRST, RUN, DRAIN, HALTED.
- An advance happens when `clk_enable=1` and `stall=0`.
- On advance in FIRST or RUN:
  - `instr_out<=instr_readdata`, `instr_pc<=pc`, `instr_valid<=1`.
  - `pc<=branch_valid ? branch_target : pc+4`. Wrap-around is modulo 2^32.
- Delay slot is implicit. The word being fetched while a branch sits in decode is at `instr_pc+4`, so it is always executed before the target.
- Transitions:
  - FIRST→RUN on the first advance.
  - RUN→DRAIN on an advance where the next PC equals `HALT_ADDRESS`, or where `branch_valid=1` with `branch_target[1:0]!=0`. In the misaligned case `fetch_error<=1` and `pc` is still loaded with the target.
  - DRAIN→HALTED on the next advance. In DRAIN, `instr_read=0`, the memory is not sampled, and `instr_out` (the delay slot) is presented with `instr_valid=1` for one advance.
  - HALTED is terminal until reset: `active=0`, `instr_valid=0`, `instr_read=0`, PC frozen.
- `branch_valid` is ignored when `stall=1`, when `clk_enable=0`, and in DRAIN, FIRST and HALTED.
- `instr_read = (state==FIRST || state==RUN)`. It does not depend on `stall`.
- `active = (state!=HALTED)`, registered through the state.

## Timing
- Reset values: `pc=RESET_VECTOR`, `instr_address=RESET_VECTOR`, `instr_read=1`, `instr_out=0`, `instr_pc=0`, `instr_valid=0`, `link_address=8`, `active=1`, `fetch_error=0`, state FIRST.
- Assertion of `reset` mid-operation forces these values immediately, without waiting for a clock edge.
- Fetch-to-decode latency is 1 advance. `instr_address` changes only on advancing edges.
- A PC of `HALT_ADDRESS` reached by sequential increment (wrap from 0xFFFFFFFC) also halts.
- Held cycles (`stall=1` or `clk_enable=0`) leave all outputs constant, including `instr_valid`. The consumer must qualify execution with the advance.
- A branch arriving in the same advance as a sequential increment to `HALT_ADDRESS`: the branch wins. The halt check uses the selected next PC.

## Structure
- `mips_cpu_pkg` holds:
  - `fetch_state_t` enum.
  - `RESET_VECTOR_DEFAULT` and `HALT_ADDRESS_DEFAULT` constants.
  - `INSTR_WIDTH=32`.
- No sub-module: the PC incrementer, next-PC mux and FSM all live in this module.

## Test plan
- **Reset and free run:** release `reset` with memory holding 0x11111111 at BFC00000 and 0x22222222 at BFC00004.
  - `instr_address` must read BFC00000, BFC00004, BFC00008.
  - `instr_out`/`instr_pc` must read 0x11111111/BFC00000, then 0x22222222/BFC00004.
  - `instr_valid` is 0 for the first cycle only; `active=1` throughout.
- **Branch with delay slot:** assert `branch_valid` with `branch_target=BFC00100` while BFC00000 is in decode.
  - Fetch order must be BFC00004 then BFC00100.
  - BFC00004 must appear in decode with `instr_valid=1`.
  - `link_address` must equal BFC00008 while BFC00000 is in decode.
- **Jump to halt:** JR to 0 at BFC00010.
  - The delay slot at BFC00014 must be delivered.
  - `instr_read=0` while `instr_address=0`.
  - `active` must fall one advance later and stay 0 for 10 more cycles.
- **Stall and clock gating:** hold `stall` for 3 cycles with `branch_valid=1` pulsed in the middle, then drop `clk_enable` for 2 cycles.
  - All outputs must be unchanged throughout.
  - The PC must then continue sequentially; the pulsed branch is not taken.
- **Misaligned target:** `branch_target=BFC00102`.
  - The delay slot must execute.
  - `fetch_error` must then be 1 and `active` must be 0.
- **Asynchronous reset mid-run:** assert `reset` between clock edges during RUN.
  - `instr_address=BFC00000`, `instr_valid=0` and `fetch_error=0` must apply before the next edge.
  - After release, operation must resume from FIRST.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the Harvard MIPS CPU.
// Holds the fetch-stage state encoding and the default reset and halt addresses.
package mips_cpu_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [INSTR_WIDTH-1:0] HALT_ADDRESS_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_FIRST  = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_DRAIN  = 2'd2,
        FETCH_HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/mips_cpu_harvard_fetch.sv
// Instruction fetch stage: owns the PC, fills the single decode register and detects halt.
// The branch delay slot falls out naturally: the word fetched alongside a branch in decode is instr_pc+4.
module mips_cpu_harvard_fetch
    import mips_cpu_pkg::*;
#(
    parameter logic [INSTR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [INSTR_WIDTH-1:0] HALT_ADDRESS = HALT_ADDRESS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_enable,
    input  logic                   stall,
    input  logic                   branch_valid,
    input  logic [INSTR_WIDTH-1:0] branch_target,
    input  logic [INSTR_WIDTH-1:0] instr_readdata,
    output logic [INSTR_WIDTH-1:0] instr_address,
    output logic                   instr_read,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [INSTR_WIDTH-1:0] instr_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] link_address,
    output logic                   active,
    output logic                   fetch_error,
    output fetch_state_t           dbg_state
);

    // Handshake: there is no ready/valid back-pressure on memory; instr_read marks a
    // fetch request whose data is consumed on an advance (clk_enable=1, stall=0), and
    // instr_valid marks instr_out as executable, to be qualified with that same advance.

    fetch_state_t           r_state;
    fetch_state_t           w_state_next;
    logic [INSTR_WIDTH-1:0] r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [INSTR_WIDTH-1:0] r_instr_pc;
    logic                   r_valid;
    logic                   r_error;

    logic [INSTR_WIDTH-1:0] w_pc_next;
    logic [INSTR_WIDTH-1:0] w_instr_next;
    logic [INSTR_WIDTH-1:0] w_instr_pc_next;
    logic                   w_valid_next;
    logic                   w_error_next;

    logic                   w_advance;
    logic                   w_branch_taken;
    logic                   w_misaligned;
    logic [INSTR_WIDTH-1:0] w_seq_pc;
    logic [INSTR_WIDTH-1:0] w_sel_pc;

    assign w_advance      = clk_enable && !stall;
    assign w_branch_taken = (r_state == FETCH_RUN) && branch_valid;
    assign w_misaligned   = w_branch_taken && (branch_target[1:0] != 2'b00);
    assign w_seq_pc       = r_pc + 32'd4;
    assign w_sel_pc       = w_branch_taken ? branch_target : w_seq_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH_FIRST;
            r_pc       <= RESET_VECTOR;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_instr_pc <= w_instr_pc_next;
            r_valid    <= w_valid_next;
            r_error    <= w_error_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_instr_pc_next = r_instr_pc;
        w_valid_next    = r_valid;
        w_error_next    = r_error;
        if (w_advance) begin
            case (r_state)
                FETCH_FIRST: begin
                    w_instr_next    = instr_readdata;
                    w_instr_pc_next = r_pc;
                    w_valid_next    = 1'b1;
                    w_pc_next       = w_seq_pc;
                    w_state_next    = FETCH_RUN;
                end
                FETCH_RUN: begin
                    w_instr_next    = instr_readdata;
                    w_instr_pc_next = r_pc;
                    w_valid_next    = 1'b1;
                    w_pc_next       = w_sel_pc;
                    // The PC still takes a misaligned target so it is visible for debug.
                    if (w_misaligned) begin
                        w_error_next = 1'b1;
                        w_state_next = FETCH_DRAIN;
                    end else if (w_sel_pc == HALT_ADDRESS) begin
                        w_state_next = FETCH_DRAIN;
                    end
                end
                FETCH_DRAIN: begin
                    w_valid_next = 1'b0;
                    w_state_next = FETCH_HALTED;
                end
                default: begin
                    w_state_next = FETCH_HALTED;
                end
            endcase
        end
    end

    assign instr_address = r_pc;
    assign instr_read    = (r_state == FETCH_FIRST) || (r_state == FETCH_RUN);
    assign instr_out     = r_instr;
    assign instr_pc      = r_instr_pc;
    assign instr_valid   = r_valid;
    assign link_address  = r_instr_pc + 32'd8;
    assign active        = (r_state != FETCH_HALTED);
    assign fetch_error   = r_error;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_mips_cpu_harvard_fetch.sv
// Directed bench for the fetch stage: a flag-based reference model checked every cycle,
// plus literal expectations for reset, branch/delay slot, halt, stall, misalignment and async reset.
module tb_mips_cpu_harvard_fetch;
    import mips_cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] instr_readdata;
    logic [31:0] instr_address;
    logic        instr_read;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] link_address;
    logic        active;
    logic        fetch_error;
    fetch_state_t dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    mips_cpu_harvard_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .stall          (stall),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .instr_readdata (instr_readdata),
        .instr_address  (instr_address),
        .instr_read     (instr_read),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .link_address   (link_address),
        .active         (active),
        .fetch_error    (fetch_error),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / memory ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h1111_1111;
        if (a == 32'hBFC0_0004) return 32'h2222_2222;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    assign instr_readdata = mem_rd(instr_address);

    // ---------------- reference model ----------------
    // started: first word taken; stopping: halt/misalign seen, delay slot pending; stopped: CPU done.
    logic [31:0] m_pc, m_iout, m_ipc;
    logic        m_ival, m_err, m_started, m_stopping, m_stopped;
    logic [31:0] m_next;
    logic        m_bad_tgt;

    assign m_next    = (m_started && branch_valid) ? branch_target : m_pc + 32'd4;
    assign m_bad_tgt = m_started && branch_valid && (branch_target[1:0] != 2'b00);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 32'hBFC0_0000; m_iout <= '0; m_ipc <= '0; m_ival <= 1'b0;
            m_err <= 1'b0; m_started <= 1'b0; m_stopping <= 1'b0; m_stopped <= 1'b0;
        end else if (clk_enable && !stall && !m_stopped) begin
            if (m_stopping) begin
                m_ival    <= 1'b0;
                m_stopped <= 1'b1;
            end else begin
                m_iout    <= mem_rd(m_pc);
                m_ipc     <= m_pc;
                m_ival    <= 1'b1;
                m_pc      <= m_next;
                m_started <= 1'b1;
                if (m_started && (m_bad_tgt || m_next == 32'h0)) m_stopping <= 1'b1;
                if (m_bad_tgt) m_err <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("mdl_addr",  instr_address, m_pc);
        chk("mdl_read",  {31'd0, instr_read}, {31'd0, !m_stopping && !m_stopped});
        chk("mdl_iout",  instr_out, m_iout);
        chk("mdl_ipc",   instr_pc, m_ipc);
        chk("mdl_valid", {31'd0, instr_valid}, {31'd0, m_ival});
        chk("mdl_link",  link_address, m_ipc + 32'd8);
        chk("mdl_active", {31'd0, active}, {31'd0, !m_stopped});
        chk("mdl_err",   {31'd0, fetch_error}, {31'd0, m_err});
    end

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        branch_valid = 1'b0;
        stall = 1'b0;
        clk_enable = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic hold_checks(input string tag);
        chk({tag, "_addr"},  instr_address, 32'hBFC0_0008);
        chk({tag, "_ipc"},   instr_pc, 32'hBFC0_0004);
        chk({tag, "_iout"},  instr_out, 32'h2222_2222);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_read"},  {31'd0, instr_read}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; stall = 1'b0;
        branch_valid = 1'b0; branch_target = '0;
        #3;
        chk("rst_addr",   instr_address, 32'hBFC0_0000);
        chk("rst_read",   {31'd0, instr_read}, 32'd1);
        chk("rst_iout",   instr_out, 32'd0);
        chk("rst_ipc",    instr_pc, 32'd0);
        chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("rst_link",   link_address, 32'd8);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_err",    {31'd0, fetch_error}, 32'd0);

        // free run
        do_reset();
        chk("run_valid0", {31'd0, instr_valid}, 32'd0);
        cyc();
        chk("run_addr1", instr_address, 32'hBFC0_0004);
        chk("run_iout1", instr_out, 32'h1111_1111);
        chk("run_ipc1",  instr_pc, 32'hBFC0_0000);
        chk("run_valid1", {31'd0, instr_valid}, 32'd1);
        cyc();
        chk("run_addr2", instr_address, 32'hBFC0_0008);
        chk("run_iout2", instr_out, 32'h2222_2222);
        chk("run_ipc2",  instr_pc, 32'hBFC0_0004);
        chk("run_active", {31'd0, active}, 32'd1);

        // branch with delay slot
        do_reset();
        cyc();
        chk("br_link", link_address, 32'hBFC0_0008);
        branch_valid = 1'b1; branch_target = 32'hBFC0_0100;
        cyc();
        branch_valid = 1'b0;
        chk("br_slot_ipc", instr_pc, 32'hBFC0_0004);
        chk("br_slot_valid", {31'd0, instr_valid}, 32'd1);
        chk("br_tgt_addr", instr_address, 32'hBFC0_0100);
        cyc();
        chk("br_tgt_ipc", instr_pc, 32'hBFC0_0100);
        chk("br_tgt_next", instr_address, 32'hBFC0_0104);

        // jump to halt
        do_reset();
        repeat (5) cyc();
        chk("jr_ipc", instr_pc, 32'hBFC0_0010);
        branch_valid = 1'b1; branch_target = 32'h0;
        cyc();
        branch_valid = 1'b0;
        chk("jr_slot_ipc", instr_pc, 32'hBFC0_0014);
        chk("jr_slot_valid", {31'd0, instr_valid}, 32'd1);
        chk("jr_addr0", instr_address, 32'h0);
        chk("jr_read0", {31'd0, instr_read}, 32'd0);
        chk("jr_active_still", {31'd0, active}, 32'd1);
        cyc();
        chk("jr_active_fall", {31'd0, active}, 32'd0);
        chk("jr_valid_fall", {31'd0, instr_valid}, 32'd0);
        chk("jr_state", {30'd0, dbg_state}, {30'd0, FETCH_HALTED});
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("jr_halted_active", {31'd0, active}, 32'd0);
            chk("jr_halted_addr", instr_address, 32'h0);
        end

        // stall and clock gating
        do_reset();
        repeat (2) cyc();
        stall = 1'b1;
        cyc(); hold_checks("stall_a");
        branch_valid = 1'b1; branch_target = 32'hBFC0_0200;
        cyc(); hold_checks("stall_b");
        branch_valid = 1'b0;
        cyc(); hold_checks("stall_c");
        stall = 1'b0; clk_enable = 1'b0;
        cyc(); hold_checks("gate_a");
        cyc(); hold_checks("gate_b");
        clk_enable = 1'b1;
        cyc();
        chk("resume_ipc", instr_pc, 32'hBFC0_0008);
        chk("resume_addr", instr_address, 32'hBFC0_000C);

        // misaligned target
        do_reset();
        cyc();
        branch_valid = 1'b1; branch_target = 32'hBFC0_0102;
        cyc();
        branch_valid = 1'b0;
        chk("mis_slot_ipc", instr_pc, 32'hBFC0_0004);
        chk("mis_slot_valid", {31'd0, instr_valid}, 32'd1);
        chk("mis_err", {31'd0, fetch_error}, 32'd1);
        chk("mis_addr", instr_address, 32'hBFC0_0102);
        chk("mis_read", {31'd0, instr_read}, 32'd0);
        cyc();
        chk("mis_active", {31'd0, active}, 32'd0);
        chk("mis_err_sticky", {31'd0, fetch_error}, 32'd1);

        // branch beats a sequential wrap to the halt address
        do_reset();
        cyc();
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFF8;
        cyc();
        branch_valid = 1'b0;
        chk("wrapb_addr", instr_address, 32'hFFFF_FFF8);
        cyc();
        chk("wrapb_addr2", instr_address, 32'hFFFF_FFFC);
        branch_valid = 1'b1; branch_target = 32'hBFC0_0300;
        cyc();
        branch_valid = 1'b0;
        chk("wrapb_win_addr", instr_address, 32'hBFC0_0300);
        chk("wrapb_win_read", {31'd0, instr_read}, 32'd1);
        chk("wrapb_win_ipc", instr_pc, 32'hFFFF_FFFC);

        // sequential wrap halts
        do_reset();
        cyc();
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFF8;
        cyc();
        branch_valid = 1'b0;
        cyc();
        cyc();
        chk("wrap_addr", instr_address, 32'h0);
        chk("wrap_read", {31'd0, instr_read}, 32'd0);
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_iout", instr_out, 32'hA5A5_A5A6);
        cyc();
        chk("wrap_active", {31'd0, active}, 32'd0);

        // asynchronous reset mid-run
        do_reset();
        repeat (3) cyc();
        chk("ar_pre_addr", instr_address, 32'hBFC0_000C);
        #2 reset = 1'b1;
        #1;
        chk("ar_addr", instr_address, 32'hBFC0_0000);
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_err", {31'd0, fetch_error}, 32'd0);
        chk("ar_ipc", instr_pc, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc();
        chk("ar_resume_ipc", instr_pc, 32'hBFC0_0000);
        chk("ar_resume_addr", instr_address, 32'hBFC0_0004);
        chk("ar_resume_iout", instr_out, 32'h1111_1111);

        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
